// File: rtl/calculator_pkg.sv
// Shared widths for the calculator datapath and its SRAM access interface.
package calculator_pkg;

  parameter int unsigned ADDR_W        = 9;
  parameter int unsigned MEM_WORD_SIZE = 64;

endpackage : calculator_pkg

// File: rtl/calc_mem_responder.sv
// Memory-side responder: services controller reads/writes from a word array,
// returns reads after a fixed latency, supports bench preload, sticky range
// errors and saturating access counters.
module calc_mem_responder #(
  parameter int unsigned ADDR_W        = calculator_pkg::ADDR_W,
  parameter int unsigned MEM_WORD_SIZE = calculator_pkg::MEM_WORD_SIZE,
  parameter int unsigned DEPTH         = 2**ADDR_W,
  parameter int unsigned READ_LATENCY  = 1,
  parameter int unsigned COUNT_W       = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     read,
  input  logic [ADDR_W-1:0]        r_addr,
  output logic [MEM_WORD_SIZE-1:0] r_data,
  output logic                     r_valid,
  input  logic                     write,
  input  logic [ADDR_W-1:0]        w_addr,
  input  logic [MEM_WORD_SIZE-1:0] w_data,
  input  logic                     init_we,
  input  logic [ADDR_W-1:0]        init_addr,
  input  logic [MEM_WORD_SIZE-1:0] init_data,
  input  logic                     err_clr_i,
  output logic                     err_o,
  output logic [COUNT_W-1:0]       rd_count,
  output logic [COUNT_W-1:0]       wr_count
);

  // Index width covers the implemented words; DEPTH may be below 2**ADDR_W.
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [MEM_WORD_SIZE-1:0] mem_q [DEPTH];

  logic [READ_LATENCY-1:0]                    vld_q;
  logic [READ_LATENCY-1:0][MEM_WORD_SIZE-1:0] dat_q;
  logic [MEM_WORD_SIZE-1:0]                   rdat_d;

  logic               err_q, err_d;
  logic [COUNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [COUNT_W-1:0] wr_cnt_q, wr_cnt_d;

  logic rd_in, wr_in, init_in;
  logic rd_ok, wr_ok, init_ok, wr_conflict, err_set;
  logic [IDX_W-1:0] r_idx, w_idx, i_idx;

  // Decode range, preload/write priority, read-data bypass and counter updates.
  always_comb begin
    rd_in       = ({1'b0, r_addr} < DEPTH_L);
    wr_in       = ({1'b0, w_addr} < DEPTH_L);
    init_in     = ({1'b0, init_addr} < DEPTH_L);
    r_idx       = r_addr[IDX_W-1:0];
    w_idx       = w_addr[IDX_W-1:0];
    i_idx       = init_addr[IDX_W-1:0];
    init_ok     = init_we && init_in;
    wr_conflict = write && init_we && (w_addr == init_addr);
    wr_ok       = write && wr_in && !wr_conflict;
    rd_ok       = read && rd_in;
    err_set     = (read && !rd_in) || (write && !wr_in) ||
                  (init_we && !init_in) || wr_conflict;

    // Write-first: a same-cycle commit to the read address is returned.
    rdat_d = '0;
    if (rd_ok) begin
      if (init_ok && (init_addr == r_addr)) begin
        rdat_d = init_data;
      end else if (wr_ok && (w_addr == r_addr)) begin
        rdat_d = w_data;
      end else begin
        rdat_d = mem_q[r_idx];
      end
    end

    // A new error outranks a same-cycle clear.
    err_d = err_q;
    if (err_set) begin
      err_d = 1'b1;
    end else if (err_clr_i) begin
      err_d = 1'b0;
    end

    rd_cnt_d = rd_cnt_q;
    if (rd_ok && (rd_cnt_q != '1)) begin
      rd_cnt_d = rd_cnt_q + COUNT_W'(1);
    end

    wr_cnt_d = wr_cnt_q;
    if (wr_ok && (wr_cnt_q != '1)) begin
      wr_cnt_d = wr_cnt_q + COUNT_W'(1);
    end
  end

  // Storage array; not reset so contents survive a reset pulse.
  always_ff @(posedge clk_i) begin
    if (wr_ok) begin
      mem_q[w_idx] <= w_data;
    end
    if (init_ok) begin
      mem_q[i_idx] <= init_data;
    end
  end

  // Latency pipeline; data stages load only with a valid so r_data holds when idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q[0] <= read;
      if (read) begin
        dat_q[0] <= rdat_d;
      end
      for (int unsigned k = 1; k < READ_LATENCY; k++) begin
        vld_q[k] <= vld_q[k-1];
        if (vld_q[k-1]) begin
          dat_q[k] <= dat_q[k-1];
        end
      end
    end
  end

  // Sticky error flag and saturating access counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q    <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      err_q    <= err_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign r_valid  = vld_q[READ_LATENCY-1];
  assign r_data   = dat_q[READ_LATENCY-1];
  assign err_o    = err_q;
  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;

endmodule : calc_mem_responder

// File: doc/calc_mem_responder.md
Name: calc_mem_responder

Overview:
Memory-side responder for the calculator's SRAM access interface. It accepts the controller's read/write requests, services them from an internal word array, and returns read data after a fixed, parameterised latency with a valid strobe. It sits between the calculator controller and storage. It also provides a preload port for the bench, sticky range-error reporting and saturating access counters.

Parameters:
ADDR_W, calculator_pkg::ADDR_W, request address width
MEM_WORD_SIZE, calculator_pkg::MEM_WORD_SIZE, memory word width
DEPTH, 2**ADDR_W, number of implemented words; legal addresses are 0..DEPTH-1
READ_LATENCY, 1, cycles from read request to r_valid; legal range 1..4
COUNT_W, 16, width of each access counter

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
read  in  1  read request, one per cycle
r_addr  in  ADDR_W  read address, sampled when read=1
r_data  out  MEM_WORD_SIZE  read response data
r_valid  out  1  r_data holds the response to a request made READ_LATENCY cycles earlier
write  in  1  write request
w_addr  in  ADDR_W  write address
w_data  in  MEM_WORD_SIZE  write data
init_we  in  1  preload write enable
init_addr  in  ADDR_W  preload address
init_data  in  MEM_WORD_SIZE  preload data
err_clr_i  in  1  clears err_o
err_o  out  1  sticky flag: an out-of-range or dropped access occurred
rd_count  out  COUNT_W  accepted in-range reads, saturating
wr_count  out  COUNT_W  accepted in-range writes, saturating

Behaviour:
- Reset (rst_ni=0, asynchronous) clears r_data, r_valid, err_o, rd_count, wr_count and all pipeline valid bits to 0. Array contents are not reset and are preserved across reset.
- Write and preload commit at the posedge where they are asserted. Preload is sampled in every cycle, including cycles where a read or write is also asserted.
- If init_we and write target the same address in the same cycle, the preload commits. The functional write is dropped, wr_count does not increment, and err_o is set. If they target different addresses, both commit.
- A read samples r_addr at posedge N and captures data into pipeline stage 1 at that edge.
- Same-cycle read and write to the same address is write-first: the read returns w_data, or init_data if a preload wins that address.
- Pipeline stages 2..READ_LATENCY only shift. A write that lands after the sampling edge does not alter a response already in flight.
- r_valid=1 and r_data=response during the cycle after edge N+READ_LATENCY-1. With READ_LATENCY=1, the response is visible in the cycle immediately after the request edge.
- When r_valid=0, r_data holds its last value.
- Back-to-back reads are accepted every cycle with no bubbles. Responses are returned strictly in request order.
- Out-of-range address (address >= DEPTH):
  - Read: accepted and returns r_data=0 with r_valid=1 at normal latency. rd_count does not increment. err_o is set.
  - Write: dropped. wr_count does not increment. err_o is set.
  - Preload: dropped. err_o is set.
- err_o is set on the edge after the offending request and stays set until err_clr_i=1 or reset. If err_clr_i and a new error occur in the same cycle, the set wins.
- rd_count and wr_count increment by 1 per accepted in-range operation and saturate at all-ones with no wrap.
- Reset asserted mid-read: in-flight responses are discarded and no r_valid follows release. The first request after release behaves normally.
- There is no internal state machine beyond the latency pipeline. The block is always ready.

Test Plan:
1. Preload addr 5=0x0000_0001_0000_0002, then read addr 5 at edge N with READ_LATENCY=1 -> r_valid=1 and r_data=0x0000_0001_0000_0002 in cycle N+1, and r_valid=0 the following cycle.
2. Same cycle: write addr 10=0xAAAA_5555_AAAA_5555 and read addr 10 -> response=0xAAAA_5555_AAAA_5555. rd_count=1 and wr_count=1.
3. READ_LATENCY=3, preload addrs 0..3 = 0x10..0x13, read 0..3 back-to-back -> r_valid high for 4 consecutive cycles starting 3 cycles after the first request, with data 0x10, 0x11, 0x12, 0x13. A write of 0xFF to addr 2 one cycle after its read does not change the returned 0x12.
4. DEPTH=256: read addr 300 -> r_data=0, r_valid=1, err_o=1 and held. Write addr 300 -> addr 300 & 0xFF unchanged and wr_count unchanged. Pulse err_clr_i -> err_o=0.
5. Preload addr 7=0x55. Issue read addr 7 with READ_LATENCY=2 and assert rst_ni=0 one cycle later -> r_valid=0 immediately and stays 0 after release. A re-read of addr 7 returns 0x55.
6. COUNT_W=4: 20 in-range reads -> rd_count=15. Then init_we and write to addr 3 in the same cycle -> preload value stored, wr_count=0, err_o=1.
